// File: rtl/decode_read_stage_pkg.sv
// Shared opcode, ALU-op and control definitions for the decode + register-read stage,
// plus the combinational decode helpers (opcode decoder and ALU-op decoder).
package decode_read_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic is_jump;
    logic is_branch;
    logic reg_we;
    logic mem_we;
    logic mem_rr;
    logic csr_write;
    logic illegal;
    logic a_sel;
    logic b_sel;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(logic [6:0] opc, logic [2:0] f3);
    ctrl_t c;
    c = '0;
    c.a_sel = 1'b1;
    c.b_sel = 1'b1;
    case (opc)
      OP_LUI:    c.reg_we = 1'b1;
      OP_AUIPC:  begin c.reg_we = 1'b1; c.a_sel = 1'b0; end
      OP_JAL:    begin c.reg_we = 1'b1; c.is_jump = 1'b1; c.a_sel = 1'b0; end
      OP_JALR:   begin c.reg_we = 1'b1; c.is_jump = 1'b1; end
      OP_BRANCH: begin c.is_jump = 1'b1; c.is_branch = 1'b1; c.a_sel = 1'b0; end
      OP_LOAD:   begin c.reg_we = 1'b1; c.mem_rr = 1'b1; end
      OP_STORE:  c.mem_we = 1'b1;
      OP_ARI_I:  c.reg_we = 1'b1;
      OP_ARI_R:  begin c.reg_we = 1'b1; c.b_sel = 1'b0; end
      OP_SYSTEM: c.csr_write = (f3 != 3'd0);
      default:   c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // {uses_rs1, uses_rs2}; only registers actually read may raise a load-use hazard
  function automatic logic [1:0] decode_src_use(logic [6:0] opc);
    case (opc)
      OP_BRANCH, OP_STORE, OP_ARI_R:              return 2'b11;
      OP_LOAD, OP_JALR, OP_ARI_I, OP_SYSTEM:      return 2'b10;
      default:                                    return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] alu_dec(logic [6:0] opc, logic [2:0] f3, logic b30);
    logic [3:0] op;
    op = ALU_ADD;
    if (opc == OP_LUI) op = ALU_PASSB;
    else if (opc == OP_BRANCH) op = ALU_SUB;
    else if (opc == OP_ARI_R || opc == OP_ARI_I) begin
      case (f3)
        3'd0:    op = (opc == OP_ARI_R && b30) ? ALU_SUB : ALU_ADD;
        3'd1:    op = ALU_SLL;
        3'd2:    op = ALU_SLT;
        3'd3:    op = ALU_SLTU;
        3'd4:    op = ALU_XOR;
        3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
        3'd6:    op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

  function automatic logic [31:0] decode_imm(logic [31:0] ins);
    case (ins[6:0])
      OP_LOAD, OP_JALR, OP_ARI_I, OP_SYSTEM:
        return {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        return {ins[31:12], 12'd0};
      OP_JAL:
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_read_stage_regfile.sv
// Architectural register file: NREGS x XLEN, two combinational read ports,
// one synchronous write port; register 0 always reads zero and ignores writes.
module decode_read_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (we_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/decode_read_stage.sv
// Decode + register-read pipeline stage with valid/ready on both sides, load-use interlock,
// flush and illegal-opcode flag. Optional writeback bypass: define DECODE_BYPASS_EN.
module decode_read_stage
  import decode_read_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_ra,
  output logic [XLEN-1:0] out_rb,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic [AW-1:0]   out_rs1,
  output logic [AW-1:0]   out_rs2_shamt,
  output logic [3:0]      out_alu_op,
  output logic [2:0]      out_funct3,
  output logic            out_a_sel,
  output logic            out_b_sel,
  output logic            out_is_jump,
  output logic            out_is_branch,
  output logic            out_reg_we,
  output logic            out_mem_we,
  output logic            out_mem_rr,
  output logic            out_csr_write,
  output logic            out_illegal,
  output logic            hazard
);

  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rf_ra, rf_rb, ra_d, rb_d, imm_d;
  logic [1:0]      src_use;
  ctrl_t           ctrl_d, ctrl_q;
  logic            accept;

  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q, out_ra_q, out_rb_q, out_imm_q;
  logic [AW-1:0]   out_rd_q, out_rs1_q, out_rs2_q;
  logic [3:0]      out_alu_op_q;
  logic [2:0]      out_funct3_q;

  assign rs1     = in_instr[15 +: AW];
  assign rs2     = in_instr[20 +: AW];
  assign rd      = in_instr[7 +: AW];
  assign ctrl_d  = decode_ctrl(in_instr[6:0], in_instr[14:12]);
  assign src_use = decode_src_use(in_instr[6:0]);
  assign imm_d   = XLEN'($signed(decode_imm(in_instr)));

  decode_read_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rf_ra),
    .rdata_b_o (rf_rb)
  );

  assign hazard = out_valid_q && ctrl_q.mem_rr && (out_rd_q != '0) &&
                  ((src_use[1] && rs1 == out_rd_q) || (src_use[0] && rs2 == out_rd_q));
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef DECODE_BYPASS_EN
  logic hold_hit_a, hold_hit_b;
  assign ra_d = (wb_we && wb_addr != '0 && wb_addr == rs1) ? wb_data : rf_ra;
  assign rb_d = (wb_we && wb_addr != '0 && wb_addr == rs2) ? wb_data : rf_rb;
  assign hold_hit_a = out_valid_q && wb_we && wb_addr != '0 && wb_addr == out_rs1_q;
  assign hold_hit_b = out_valid_q && wb_we && wb_addr != '0 && wb_addr == out_rs2_q;
`else
  assign ra_d = rf_ra;
  assign rb_d = rf_rb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      ctrl_q       <= '0;
      out_pc_q     <= '0;
      out_ra_q     <= '0;
      out_rb_q     <= '0;
      out_imm_q    <= '0;
      out_rd_q     <= '0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_alu_op_q <= '0;
      out_funct3_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      ctrl_q       <= ctrl_d;
      out_pc_q     <= in_pc;
      out_ra_q     <= ra_d;
      out_rb_q     <= rb_d;
      out_imm_q    <= imm_d;
      out_rd_q     <= rd;
      out_rs1_q    <= rs1;
      out_rs2_q    <= rs2;
      out_alu_op_q <= alu_dec(in_instr[6:0], in_instr[14:12], in_instr[30]);
      out_funct3_q <= in_instr[14:12];
    end else if (out_ready) begin
      // drained with nothing to refill: bubble with every enable cleared
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else begin
`ifdef DECODE_BYPASS_EN
      if (hold_hit_a) out_ra_q <= wb_data;
      if (hold_hit_b) out_rb_q <= wb_data;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_ra        = out_ra_q;
  assign out_rb        = out_rb_q;
  assign out_imm       = out_imm_q;
  assign out_rd        = out_rd_q;
  assign out_rs1       = out_rs1_q;
  assign out_rs2_shamt = out_rs2_q;
  assign out_alu_op    = out_alu_op_q;
  assign out_funct3    = out_funct3_q;
  assign out_a_sel     = ctrl_q.a_sel;
  assign out_b_sel     = ctrl_q.b_sel;
  assign out_is_jump   = ctrl_q.is_jump;
  assign out_is_branch = ctrl_q.is_branch;
  assign out_reg_we    = ctrl_q.reg_we;
  assign out_mem_we    = ctrl_q.mem_we;
  assign out_mem_rr    = ctrl_q.mem_rr;
  assign out_csr_write = ctrl_q.csr_write;
  assign out_illegal   = ctrl_q.illegal;

endmodule
